sigmoid_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency sigmoid pipeline among NREQ activation requesters. It sits between the neuron accumulator lanes and the single sigmoid unit. It issues at most one operand per cycle and tracks each in-flight operand's requester ID in a tag pipeline matched to the unit's latency. It routes each result back to its originator and supports a hold/drain handshake so the unit can be quiesced for reconfiguration.

---
 rtl/sigmoid_sched_pkg.sv | 31 +++
 rtl/sigmoid_sched_rr_arbiter.sv | 78 +++++++
 rtl/sigmoid_sched.sv | 176 +++++++++++++++++
 tb/tb_sigmoid_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_sched_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_sched_pkg
//   Shared types and build constants for the sigmoid scheduler slice.
//   - SCHED_NREQ : number of accumulator lanes sharing the sigmoid unit (2..8)
//   - SCHED_DW   : operand/result width
//   - SCHED_LAT  : sigmoid unit latency, act_x valid -> act_o valid
//   - IDW        : requester-id width
//   - state_e    : scheduler FSM states
//   - tag_t      : one tag-pipeline stage {valid, id}
//   The requester count is fixed here, not at the top level, because the tag
//   and rsp_id widths are derived from it.
// -----------------------------------------------------------------------------
package sigmoid_sched_pkg;

   localparam int SCHED_NREQ = 4;
   localparam int SCHED_DW   = 32;
   localparam int SCHED_LAT  = 4;
   localparam int IDW        = $clog2(SCHED_NREQ);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HELD  = 2'd2
   } state_e;

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
   } tag_t;

endpackage : sigmoid_sched_pkg

// File: rtl/sigmoid_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter with a registered search pointer.
//   The search starts at ptr and walks upward (mod NREQ). The first valid
//   request wins. When advance is asserted, the pointer moves to the
//   position just past the winner, so the winner drops to lowest priority.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset (ptr -> 0)
//     req         : per-requester request vector
//     advance     : a transfer happened to the current winner this cycle
//     grant       : one-hot winner (all-zero if no request)
//     grant_idx   : binary index of the winner
//     grant_valid : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
   import sigmoid_sched_pkg::*;
#(
   parameter int NREQ = SCHED_NREQ,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            grant_valid
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;

   // Candidate k is the requester searched k-th: (ptr + k) mod NREQ.
   // The sum uses one spare bit so the wrap compare cannot overflow.
   logic [IW:0]   sum_w [NREQ];
   logic [IW-1:0] cand  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         assign sum_w[gi] = {1'b0, ptr_q} + (IW+1)'(gi);
         assign cand[gi]  = (sum_w[gi] >= (IW+1)'(NREQ))
                          ? IW'(sum_w[gi] - (IW+1)'(NREQ))
                          : sum_w[gi][IW-1:0];
      end
   endgenerate

   // Walk the candidates from last to first so the earliest valid
   // candidate is the final assignment. This avoids a break statement.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[k];
         end
      end
   end

   assign grant = grant_valid ? (NREQ'(1) << grant_idx) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule : rr_arbiter

// File: rtl/sigmoid_sched.sv
// -----------------------------------------------------------------------------
// sigmoid_sched
//   Shares one fixed-latency sigmoid unit among SCHED_NREQ accumulator lanes.
//   It issues at most one operand per cycle through a round-robin arbiter.
//   A tag pipeline of LAT+1 stages tracks the owner of each in-flight
//   operand. Each result is registered and returned with its owner's id.
//   hold stops issue and lets the pipeline drain. hold_ack reports that the
//   unit is quiescent.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     req_valid   : per-requester operand valid
//     req_x       : packed operands, requester i at [i*DW +: DW]
//     req_ready   : one-hot grant (transfer = req_valid & req_ready)
//     act_x       : registered operand to the sigmoid unit
//     act_o       : sigmoid unit result, LAT cycles after act_x
//     rsp_valid   : single-cycle result strobe
//     rsp_id      : owner of rsp_data
//     rsp_data    : registered copy of act_o
//     hold        : stop issuing and drain
//     hold_ack    : held and pipeline empty
//     busy        : any operand in flight
// -----------------------------------------------------------------------------
module sigmoid_sched
   import sigmoid_sched_pkg::*;
#(
   parameter int DW  = SCHED_DW,
   parameter int LAT = SCHED_LAT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SCHED_NREQ-1:0]    req_valid,
   input  logic [SCHED_NREQ*DW-1:0] req_x,
   output logic [SCHED_NREQ-1:0]    req_ready,
   output logic [DW-1:0]            act_x,
   input  logic [DW-1:0]            act_o,
   output logic                     rsp_valid,
   output logic [IDW-1:0]           rsp_id,
   output logic [DW-1:0]            rsp_data,
   input  logic                     hold,
   output logic                     hold_ack,
   output logic                     busy
);

   localparam int NREQ = SCHED_NREQ;

   state_e state_q, state_d;

   logic [NREQ-1:0] arb_grant;
   logic [IDW-1:0]  arb_idx;
   logic            arb_valid;
   logic            issue_en;
   logic            xfer;

   logic [DW-1:0]   act_x_q;
   tag_t [LAT:0]    tag_q;
   tag_t [LAT:0]    tag_d;
   logic [LAT:0]    stage_valid;

   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [DW-1:0]   rsp_data_q;

   // ---------------------------------------------------------------- arbiter
   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (req_valid),
      .advance     (xfer),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // hold is decoded combinationally, so req_ready drops in the same
   // cycle hold rises. Returning from DRAIN does not disturb in-flight tags.
   always_comb begin
      state_d  = state_q;
      issue_en = 1'b0;
      hold_ack = 1'b0;
      unique case (state_q)
         RUN: begin
            issue_en = !hold && !reset;
            if (hold) begin
               state_d = busy ? DRAIN : HELD;
            end
         end
         DRAIN: begin
            if (!hold) begin
               state_d = RUN;
            end else if (!busy) begin
               state_d = HELD;
            end
         end
         HELD: begin
            hold_ack = !busy && !reset;
            if (!hold) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign req_ready = issue_en ? arb_grant : '0;
   assign xfer      = issue_en && arb_valid;

   // ------------------------------------------------------------ operand reg
   // act_x keeps its old value on idle slots. The unit still produces an
   // output for those slots, but no valid tag follows it, so it is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         act_x_q <= '0;
      end else if (xfer) begin
         act_x_q <= req_x[arb_idx*DW +: DW];
      end
   end

   assign act_x = act_x_q;

   // ---------------------------------------------------------- tag pipeline
   // Stage 0 lines up with act_x and stage LAT lines up with act_o.
   genvar gi;
   generate
      for (gi = 0; gi <= LAT; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_d[gi] = tag_t'{valid: xfer, id: arb_idx};
         end else begin : g_shift
            assign tag_d[gi] = tag_q[gi-1];
         end
         assign stage_valid[gi] = tag_q[gi].valid;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign busy = |stage_valid;

   // -------------------------------------------------------------- response
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= tag_q[LAT].valid;
         if (tag_q[LAT].valid) begin
            rsp_id_q   <= tag_q[LAT].id;
            rsp_data_q <= act_o;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule : sigmoid_sched

// File: tb/tb_sigmoid_sched.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_sched
//   Bench for sigmoid_sched with a behavioural sigmoid unit, f(x) = 12*x + 34,
//   delayed LAT cycles. Every observed transfer pushes {id, f(x), due cycle}
//   onto a queue. Every rsp_valid pops that queue and is compared in order.
// -----------------------------------------------------------------------------
module tb_sigmoid_sched;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int LAT  = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_x;
   logic [NREQ-1:0]      req_ready;
   logic [DW-1:0]        act_x;
   logic [DW-1:0]        act_o;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [DW-1:0]        rsp_data;
   logic                 hold;
   logic                 hold_ack;
   logic                 busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
      int             due;
   } exp_t;

   exp_t exp_q[$];

   sigmoid_sched #(
      .DW  (DW),
      .LAT (LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .act_x     (act_x),
      .act_o     (act_o),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .hold      (hold),
      .hold_ack  (hold_ack),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] sig_model(input logic [DW-1:0] x);
      return x * 32'd12 + 32'd34;
   endfunction

   // Sigmoid unit model: act_o in cycle c is f(act_x from cycle c-LAT).
   logic [DW-1:0] hist [LAT];
   always @(posedge clk) begin
      hist[0] <= act_x;
      for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
   end
   assign act_o = sig_model(hist[LAT-1]);

   // Scoreboard: push on each transfer, pop on each rsp_valid.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0) begin
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL rsp_missing: cycle %0d got no response, required id=%0d at cycle %0d",
                     cyc, exp_q[0].id, exp_q[0].due);
            exp_q.delete(0);
         end
         if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected: cycle %0d got id=%0d data=%0d, required none",
                        cyc, rsp_id, rsp_data);
            end else begin
               e = exp_q.pop_front();
               if (rsp_id !== e.id || rsp_data !== e.data || cyc != e.due) begin
                  failures++;
                  $display("FAIL rsp_match: got id=%0d data=%0d cycle=%0d, required id=%0d data=%0d cycle=%0d",
                           rsp_id, rsp_data, cyc, e.id, e.data, e.due);
               end else begin
                  $display("rsp  cycle=%0d id=%0d data=%0d", cyc, rsp_id, rsp_data);
               end
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_q.push_back('{id: IDW'(i), data: sig_model(req_x[i*DW +: DW]),
                                 due: cyc + 2 + LAT});
               $display("xfer cycle=%0d id=%0d x=%0d", cyc, i, req_x[i*DW +: DW]);
            end
         end
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_x();
      for (int i = 0; i < NREQ; i++) req_x[i*DW +: DW] = $urandom_range(1, 100000);
   endtask

   task automatic do_reset(input int n);
      reset     = 1'b1;
      req_valid = '0;
      hold      = 1'b0;
      exp_q.delete();
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (exp_q.size() == 0 && busy === 1'b0 && rsp_valid === 1'b0) done = 1'b1;
         else step();
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: pending=%0d busy=%b, required pending=0 busy=0",
                  exp_q.size(), busy);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      reset     = 1'b1;
      hold      = 1'b0;
      req_valid = '1;
      rand_x();
      step();
      step();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ready: got %b, required 0000", req_ready);
      end
      step();
      reset     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (act_x !== '0) begin failures++; $display("FAIL reset_act_x: got %0d, required 0", act_x); end
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
      checks++;
      if (rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
      checks++;
      if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data: got %0d, required 0", rsp_data); end
      checks++;
      if (hold_ack !== 1'b0) begin failures++; $display("FAIL reset_hold_ack: got %b, required 0", hold_ack); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
      step();
      req_valid = '1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_ptr: got %b, required 0001", req_ready); end
      step();
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_single();
      req_x[2*DW +: DW] = 32'd100;
      req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b, required 0100", req_ready); end
      step();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (act_x !== 32'd100) begin failures++; $display("FAIL single_act_x: got %0d, required 100", act_x); end
      for (int k = 2; k <= 6; k++) begin
         step();
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'(k == 6)) begin
            failures++;
            $display("FAIL single_rsp_timing: t+%0d got rsp_valid=%b, required %b", k, rsp_valid, k == 6);
         end
      end
      checks++;
      if (rsp_id !== 2'd2 || rsp_data !== 32'd1234) begin
         failures++;
         $display("FAIL single_rsp: got id=%0d data=%0d, required id=2 data=1234", rsp_id, rsp_data);
      end
      step();
      wait_idle();
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_g;
      do_reset(2);
      req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         rand_x();
         exp_g = 4'b0001 << (i % NREQ);
         @(negedge clk);
         checks++;
         if (req_ready !== exp_g) begin
            failures++;
            $display("FAIL rr_grant: step %0d got %b, required %b", i, req_ready, exp_g);
         end
         step();
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_priority();
      logic [NREQ-1:0] exp_seq [3];
      exp_seq[0] = 4'b1000;
      exp_seq[1] = 4'b0010;
      exp_seq[2] = 4'b1000;
      rand_x();
      req_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin failures++; $display("FAIL prio_setup: got %b, required 0010", req_ready); end
      step();
      req_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== exp_seq[i]) begin
            failures++;
            $display("FAIL prio_grant: step %0d got %b, required %b", i, req_ready, exp_seq[i]);
         end
         step();
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_hold_drain();
      rand_x();
      req_valid = '1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (!$onehot(req_ready)) begin failures++; $display("FAIL drain_burst: got %b, required one-hot", req_ready); end
         step();
      end
      hold = 1'b1;
      for (int c = 3; c <= 10; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000) begin failures++; $display("FAIL drain_ready: t0+%0d got %b, required 0000", c, req_ready); end
         checks++;
         if (busy !== 1'(c <= 7)) begin failures++; $display("FAIL drain_busy: t0+%0d got %b, required %b", c, busy, c <= 7); end
         checks++;
         if (hold_ack !== 1'(c >= 9)) begin failures++; $display("FAIL drain_hold_ack: t0+%0d got %b, required %b", c, hold_ack, c >= 9); end
         step();
      end
      hold = 1'b0;
      @(negedge clk);
      checks++;
      if (hold_ack !== 1'b1 || req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL release_same_cycle: got hold_ack=%b ready=%b, required 1 0000", hold_ack, req_ready);
      end
      step();
      @(negedge clk);
      checks++;
      if (hold_ack !== 1'b0 || !$onehot(req_ready)) begin
         failures++;
         $display("FAIL release_next_cycle: got hold_ack=%b ready=%b, required 0 one-hot", hold_ack, req_ready);
      end
      step();
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_reset_midflight();
      rand_x();
      req_valid = '1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (!$onehot(req_ready)) begin failures++; $display("FAIL mid_burst: got %b, required one-hot", req_ready); end
         step();
      end
      reset     = 1'b1;
      req_valid = '0;
      exp_q.delete();
      step();
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_dropped: +%0d got rsp_valid=%b, required 0", c, rsp_valid); end
         checks++;
         if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: +%0d got %b, required 0", c, busy); end
         step();
      end
      req_valid = '1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr: got %b, required 0001", req_ready); end
      step();
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_hold_release();
      rand_x();
      req_valid = 4'b0011;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (!$onehot(req_ready)) begin failures++; $display("FAIL hr_burst: got %b, required one-hot", req_ready); end
         step();
      end
      req_valid = '0;
      hold      = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL hr_busy: got %b, required 1", busy); end
      step();
      hold      = 1'b0;
      req_valid = '1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || hold_ack !== 1'b0) begin
         failures++;
         $display("FAIL hr_in_drain: got ready=%b hold_ack=%b, required 0000 0", req_ready, hold_ack);
      end
      step();
      @(negedge clk);
      checks++;
      if (!$onehot(req_ready)) begin failures++; $display("FAIL hr_resume: got %b, required one-hot", req_ready); end
      step();
      req_valid = '0;
      wait_idle();
   endtask

   initial begin
      reset     = 1'b1;
      hold      = 1'b0;
      req_valid = '0;
      req_x     = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_priority();
      test_hold_drain();
      test_reset_midflight();
      test_hold_release();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover: got %0d pending responses, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sigmoid_sched
